vol_ctrl_stereo: RTL and testbench

- Clocked, parametrised successor to the front-panel volume setter.
- Debounces UP/DOWN buttons and supports press-and-hold auto-repeat.
- Keeps independent left/right attenuation with saturating steps.
- Hands each new SCI_VOL word to the decoder register-write sequencer over a valid/ready handshake; changes made while a write is pending are coalesced.

---
 rtl/vol_ctrl_stereo.sv | 227 ++++++++++++++++++++++
 tb/tb_vol_ctrl_stereo.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vol_ctrl_stereo.sv
// rtl/vol_ctrl_stereo.sv - stereo volume setter: debounced buttons, auto-repeat, coalesced SCI_VOL writes
// Optional feature macro: VOL_MUTE_EN (adds MUTE button and a mute flag)
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   UP, DOWN        raw buttons; UP = louder (less attenuation), DOWN = quieter
//   MUTE            raw mute toggle button (VOL_MUTE_EN only)
//   SEL             channel select: 00/11 both, 01 left, 10 right
//   VOL, VOL_VALID  SCI_VOL write request; VOL is stable while VOL_VALID=1
//   VOL_READY       sequencer accept; transfer on VOL_VALID & VOL_READY
//   BUSY            write pending or target differs from VOL
`timescale 1ns/1ps
module vol_ctrl_stereo #(
  parameter int              CH_W       = 8,
  parameter logic [CH_W-1:0] STEP       = 8'h10,
  parameter logic [CH_W-1:0] ATT_MIN    = 8'h00,
  parameter logic [CH_W-1:0] ATT_MAX    = 8'hF0,
  parameter logic [CH_W-1:0] ATT_RST    = 8'h40,
  parameter int              DEB_CYCLES = 1000000,
  parameter int              RPT_DLY    = 50000000,
  parameter int              RPT_PER    = 10000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UP,
  input  logic              DOWN,
`ifdef VOL_MUTE_EN
  input  logic              MUTE,
`endif
  input  logic [1:0]        SEL,
  output logic [2*CH_W-1:0] VOL,
  output logic              VOL_VALID,
  input  logic              VOL_READY,
  output logic              BUSY
);

`ifdef VOL_MUTE_EN
  localparam int NB = 3;
  localparam int B_MU = 2;
`else
  localparam int NB = 2;
`endif
  localparam int B_UP = 0;
  localparam int B_DN = 1;

  localparam int CNT_MAX = (DEB_CYCLES > RPT_DLY)
                         ? ((DEB_CYCLES > RPT_PER) ? DEB_CYCLES : RPT_PER)
                         : ((RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_C    = CNT_W'(RPT_DLY);
  localparam logic [CNT_W-1:0] PER_C    = CNT_W'(RPT_PER);
  localparam logic [2*CH_W-1:0] VOL_RST = {ATT_RST, ATT_RST};

  // ---------------------------------------------------------------- inputs
  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [CNT_W-1:0] deb_cnt_q [NB];
  logic [NB-1:0]    rise;

  always_comb begin
`ifdef VOL_MUTE_EN
    raw = {MUTE, DOWN, UP};
`else
    raw = {DOWN, UP};
`endif
  end

  // The debounced level flips only after DEB_CYCLES consecutive cycles of the
  // synchronised level disagreeing with it; any agreement restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise = deb_q & ~deb_prev_q;

  // ---------------------------------------------------------------- repeat
  // Index 0 = UP, 1 = DOWN. A button counts as held only while the other one
  // is released, so holding both parks both counters at zero and the survivor
  // restarts with the full first-repeat delay.
  logic [1:0]       held, rpt_fire, rpt_seen_q;
  logic [CNT_W-1:0] rpt_cnt_q [2];
  logic             step_up, step_dn;

  always_comb begin
    held[0] = deb_q[B_UP] & ~deb_q[B_DN];
    held[1] = deb_q[B_DN] & ~deb_q[B_UP];
    for (int b = 0; b < 2; b++) begin
      rpt_fire[b] = held[b] & (rpt_cnt_q[b] == (rpt_seen_q[b] ? PER_C : DLY_C));
    end
    step_up = (rise[B_UP] & held[0]) | rpt_fire[0];
    step_dn = (rise[B_DN] & held[1]) | rpt_fire[1];
  end

  // rpt_cnt_q counts cycles since the last step of this button.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rpt_seen_q <= '0;
      for (int b = 0; b < 2; b++) rpt_cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (!held[b]) begin
          rpt_cnt_q[b]  <= '0;
          rpt_seen_q[b] <= 1'b0;
        end else if (rpt_fire[b]) begin
          rpt_cnt_q[b]  <= CNT_W'(1);
          rpt_seen_q[b] <= 1'b1;
        end else begin
          rpt_cnt_q[b]  <= rpt_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- target
  // One extra bit keeps the saturation compares free of wrap-around.
  function automatic logic [CH_W-1:0] att_louder(input logic [CH_W-1:0] t);
    logic [CH_W:0] floor_w;
    floor_w = {1'b0, ATT_MIN} + {1'b0, STEP};
    return ({1'b0, t} < floor_w) ? ATT_MIN : t - STEP;
  endfunction

  function automatic logic [CH_W-1:0] att_quieter(input logic [CH_W-1:0] t);
    logic [CH_W:0] sum_w;
    sum_w = {1'b0, t} + {1'b0, STEP};
    return (sum_w > {1'b0, ATT_MAX}) ? ATT_MAX : sum_w[CH_W-1:0];
  endfunction

  logic [CH_W-1:0] tgt_l_q, tgt_r_q, tgt_l_d, tgt_r_d;
  logic            sel_l, sel_r;

  always_comb begin
    sel_l   = (SEL != 2'b10);
    sel_r   = (SEL != 2'b01);
    tgt_l_d = tgt_l_q;
    tgt_r_d = tgt_r_q;
    if (step_up) begin
      if (sel_l) tgt_l_d = att_louder(tgt_l_q);
      if (sel_r) tgt_r_d = att_louder(tgt_r_q);
    end else if (step_dn) begin
      if (sel_l) tgt_l_d = att_quieter(tgt_l_q);
      if (sel_r) tgt_r_d = att_quieter(tgt_r_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tgt_l_q <= ATT_RST;
      tgt_r_q <= ATT_RST;
    end else begin
      tgt_l_q <= tgt_l_d;
      tgt_r_q <= tgt_r_d;
    end
  end

  // ---------------------------------------------------------------- mute
  logic [2*CH_W-1:0] cmp_word;
`ifdef VOL_MUTE_EN
  localparam logic [CH_W-1:0] MUTE_CH = {{(CH_W-1){1'b1}}, 1'b0};
  logic mute_q;

  always_ff @(posedge CLK) begin
    if (RST)             mute_q <= 1'b0;
    else if (rise[B_MU]) mute_q <= ~mute_q;
  end

  assign cmp_word = mute_q ? {MUTE_CH, MUTE_CH} : {tgt_l_q, tgt_r_q};
`else
  assign cmp_word = {tgt_l_q, tgt_r_q};
`endif

  // ---------------------------------------------------------------- transfer
  typedef enum logic {S_IDLE, S_SEND} state_t;
  state_t            state_q;
  logic [2*CH_W-1:0] vol_q;
  logic              valid_q;

  // Steps landing during SEND only move the target; the IDLE compare after the
  // handshake then issues one write with the latest value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      vol_q   <= VOL_RST;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmp_word != vol_q) begin
            vol_q   <= cmp_word;
            valid_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (VOL_READY) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign VOL       = vol_q;
  assign VOL_VALID = valid_q;
  assign BUSY      = valid_q | (cmp_word != vol_q);

endmodule

// File: tb/tb_vol_ctrl_stereo.sv
// tb/tb_vol_ctrl_stereo.sv - scoreboard bench for vol_ctrl_stereo
`timescale 1ns/1ps
module tb_vol_ctrl_stereo;
  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 5;
  localparam int A_MIN = 'h00;
  localparam int A_MAX = 'hF0;
  localparam int A_STEP = 'h10;
  localparam int A_RST = 'h40;

  logic        CLK = 1'b0;
  logic        RST, UP, DOWN, VOL_READY;
  logic [1:0]  SEL;
  logic [15:0] VOL;
  logic        VOL_VALID, BUSY;
`ifdef VOL_MUTE_EN
  logic        MUTE;
`endif

  always #5 CLK = ~CLK;

  vol_ctrl_stereo #(
    .DEB_CYCLES(DEB),
    .RPT_DLY   (DLY),
    .RPT_PER   (PER)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .UP       (UP),
    .DOWN     (DOWN),
`ifdef VOL_MUTE_EN
    .MUTE     (MUTE),
`endif
    .SEL      (SEL),
    .VOL      (VOL),
    .VOL_VALID(VOL_VALID),
    .VOL_READY(VOL_READY),
    .BUSY     (BUSY)
  );

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rdy_mode = 1;
  int          t_press = 0;
  logic [15:0] exp_q[$];
  int          hs_cyc[$];
  int          m_l, m_r;
  logic [15:0] m_vol;
  bit          m_mute;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_vol = '0;
  logic [15:0] exp_w;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------ reference model
  function automatic int louder(input int t);
    return (t < A_MIN + A_STEP) ? A_MIN : t - A_STEP;
  endfunction

  function automatic int quieter(input int t);
    return (t > A_MAX - A_STEP) ? A_MAX : t + A_STEP;
  endfunction

  // Repeat steps produced while a button is solely held for len cycles.
  function automatic int n_rpt(input int len);
    return (len - 1 >= DLY) ? (len - 1 - DLY) / PER + 1 : 0;
  endfunction

  function automatic logic [15:0] cur_word();
    logic [7:0] l8, r8;
    l8 = m_l[7:0];
    r8 = m_r[7:0];
    return m_mute ? 16'hFEFE : {l8, r8};
  endfunction

  task automatic model_step(input bit up, input logic [1:0] sel);
    if (sel != 2'b10) m_l = up ? louder(m_l) : quieter(m_l);
    if (sel != 2'b01) m_r = up ? louder(m_r) : quieter(m_r);
  endtask

  task automatic push_if_changed();
    if (cur_word() != m_vol) begin
      m_vol = cur_word();
      exp_q.push_back(m_vol);
    end
  endtask

  // ------------------------------------------------ monitor
  always @(negedge CLK) begin
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (VOL_VALID && prev_stall) chk("vol_stable", int'(VOL), int'(prev_vol));
      if (VOL_VALID && VOL_READY) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: got %0h expected none", VOL);
        end else begin
          exp_w = exp_q.pop_front();
          chk("write", int'(VOL), int'(exp_w));
        end
      end
      prev_stall = VOL_VALID && !VOL_READY;
      prev_vol   = VOL;
    end
  end

  // ------------------------------------------------ ready driver
  initial begin
    int low_run = 0;
    VOL_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (rdy_mode == 0) VOL_READY = 1'b0;
      else if (rdy_mode == 1) VOL_READY = 1'b1;
      else if (low_run < 2 && $urandom_range(0, 2) == 0) begin
        VOL_READY = 1'b0;
        low_run++;
      end else begin
        VOL_READY = 1'b1;
        low_run = 0;
      end
    end
  end

  // ------------------------------------------------ stimulus
  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete();
    hs_cyc.delete();
    m_l = A_RST;
    m_r = A_RST;
    m_vol = 16'h4040;
    m_mute = 1'b0;
  endtask

  // btn: 0 UP, 1 DOWN, 2 MUTE. Expected writes are queued at press time.
  task automatic press(input int btn, input logic [1:0] sel, input int hold,
                       input int gap, input bit push);
    @(posedge CLK); #1;
    SEL = sel;
    if (btn == 0) UP = 1'b1;
    else if (btn == 1) DOWN = 1'b1;
`ifdef VOL_MUTE_EN
    else MUTE = 1'b1;
`endif
    t_press = cyc;
    if (btn == 2) begin
      m_mute = !m_mute;
      if (push) push_if_changed();
    end else begin
      for (int i = 0; i < 1 + n_rpt(hold); i++) begin
        model_step(btn == 0, sel);
        if (push) push_if_changed();
      end
    end
    repeat (hold) @(posedge CLK);
    #1;
    UP = 1'b0;
    DOWN = 1'b0;
`ifdef VOL_MUTE_EN
    MUTE = 1'b0;
`endif
    repeat (gap) @(posedge CLK);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || VOL_VALID || BUSY) && n < 300) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  function automatic int hs_at(input int i);
    return (i < hs_cyc.size()) ? hs_cyc[i] : -1000;
  endfunction

  initial begin
    int wn;
    RST = 1'b1; UP = 1'b0; DOWN = 1'b0; SEL = 2'b00;
`ifdef VOL_MUTE_EN
    MUTE = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    do_reset();
    chk("rst_vol", int'(VOL), 'h4040);
    chk("rst_valid", int'(VOL_VALID), 0);
    chk("rst_busy", int'(BUSY), 0);

    // single DOWN press: 2 sync + DEB debounce + 2 to VALID
    press(1, 2'b00, 8, 12, 1'b1);
    drain("t1_drain");
    chk("t1_latency", hs_at(0) - t_press, 2 + DEB + 2);
    chk("t1_writes", hs_cyc.size(), 1);
    chk("t1_vol", int'(VOL), 'h5050);

    // UP x5 on left: fifth step saturates with no write
    do_reset();
    for (int i = 0; i < 5; i++) press(0, 2'b01, 6, 10, 1'b1);
    drain("t2_drain");
    chk("t2_writes", hs_cyc.size(), 4);
    chk("t2_vol", int'(VOL), 'h0040);

    // held DOWN on right with auto-repeat up to saturation
    do_reset();
    press(1, 2'b10, 71, 12, 1'b1);
    drain("t3_drain");
    chk("t3_writes", hs_cyc.size(), 11);
    chk("t3_vol", int'(VOL), 'h40F0);
    chk("t3_first_rpt", hs_at(1) - hs_at(0), DLY);
    for (int i = 2; i < hs_cyc.size(); i++) chk("t3_rpt_period", hs_at(i) - hs_at(i - 1), PER);

    // coalescing behind a stalled sequencer
    do_reset();
    rdy_mode = 0;
    press(1, 2'b00, 6, 12, 1'b1);
    press(1, 2'b00, 6, 12, 1'b0);
    press(1, 2'b00, 6, 12, 1'b0);
    chk("t4_held_vol", int'(VOL), 'h5050);
    chk("t4_held_valid", int'(VOL_VALID), 1);
    push_if_changed();
    rdy_mode = 1;
    drain("t4_drain");
    chk("t4_writes", hs_cyc.size(), 2);
    chk("t4_vol", int'(VOL), 'h7070);

    // both held, then DOWN released: UP repeats from a fresh delay
    do_reset();
    @(posedge CLK); #1;
    SEL = 2'b00; UP = 1'b1; DOWN = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    DOWN = 1'b0;
    t_press = cyc;
    for (int i = 0; i < n_rpt(27); i++) begin
      model_step(1'b1, 2'b00);
      push_if_changed();
    end
    repeat (27) @(posedge CLK);
    #1;
    UP = 1'b0;
    repeat (12) @(posedge CLK);
    drain("t5_drain");
    chk("t5_latency", hs_at(0) - t_press, 2 + DEB + DLY + 2);
    chk("t5_writes", hs_cyc.size(), 2);
    chk("t5_vol", int'(VOL), 'h2020);

    // reset during SEND
    do_reset();
    rdy_mode = 0;
    press(1, 2'b00, 6, 0, 1'b0);
    wn = 0;
    while (!VOL_VALID && wn < 30) begin
      @(posedge CLK); #1;
      wn++;
    end
    chk("t6_valid_seen", int'(VOL_VALID), 1);
    do_reset();
    chk("t6_vol", int'(VOL), 'h4040);
    chk("t6_valid", int'(VOL_VALID), 0);
    chk("t6_busy", int'(BUSY), 0);
    rdy_mode = 1;
    repeat (30) @(posedge CLK);
    drain("t6_drain");
    chk("t6_writes", hs_cyc.size(), 0);

`ifdef VOL_MUTE_EN
    do_reset();
    press(2, 2'b00, 6, 12, 1'b1);
    press(1, 2'b00, 6, 12, 1'b1);
    press(2, 2'b00, 6, 12, 1'b1);
    drain("t7_drain");
    chk("t7_writes", hs_cyc.size(), 2);
    chk("t7_vol", int'(VOL), 'h5050);
`endif

    // randomized single-step presses with a stalling sequencer
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      press(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            int'($urandom_range(6, 15)), int'($urandom_range(10, 16)), 1'b1);
    end
    rdy_mode = 1;
    drain("t8_drain");
    chk("t8_vol", int'(VOL), int'(m_vol));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
